// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: rebuilds raster coordinates from the sync stream,
// checks timing, locks to the frame and reports per-frame red/green statistics.
module vga_frame_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int H_START         = 144,
    parameter int V_START         = 35,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        ClkPort,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    output logic        locked,
    output logic        frame_valid,
    output logic        bird_found,
    output logic [9:0]  bird_x_min,
    output logic [9:0]  bird_x_max,
    output logic [9:0]  bird_y_min,
    output logic [9:0]  bird_y_max,
    output logic [18:0] red_count,
    output logic        collision,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_MEASURING = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    localparam logic [10:0] HT  = 11'(H_TOTAL);
    localparam logic [10:0] VT  = 11'(V_TOTAL);
    localparam logic [9:0]  HS  = 10'(H_START);
    localparam logic [9:0]  HE  = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]  VS  = 10'(V_START);
    localparam logic [9:0]  VE  = 10'(V_START + V_ACTIVE);
    localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);
    localparam logic        SAL = (SYNC_ACTIVE_LOW != 0);

    logic        hs_s, vs_s, h_edge_s, v_edge_s, y_restart_s, active_s, acc_en_s;
    logic        hs_prev_q, vs_prev_q, h_ph_q, v_ph_q, y_ph_q, vs_pend_q;
    logic [9:0]  x_q, x_d, y_q, y_d, ax_s, ay_s;
    logic        err_h_s, err_v_s, err_o_s, err_b_s, any_err_s, unlock_s, publish_s;
    logic [8:0]  err_sum_s;
    logic [7:0]  err_d, err_q;
    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        locked_q, fv_q, found_q, col_q;
    logic [9:0]  xmin_q, xmax_q, ymin_q, ymax_q;
    logic [18:0] cnt_q;
    logic        acc_found_q, acc_col_q;
    logic [9:0]  acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
    logic [18:0] acc_cnt_q;

    // Sync polarity decode and assert-edge detection against the previous strobe.
    always_comb begin
        hs_s        = vga_h_sync ^ SAL;
        vs_s        = vga_v_sync ^ SAL;
        h_edge_s    = pix_en & hs_s & ~hs_prev_q;
        v_edge_s    = pix_en & vs_s & ~vs_prev_q;
        y_restart_s = h_edge_s & (v_edge_s | vs_pend_q);
    end

    // Coordinates of the pixel carried by the current strobe.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (h_edge_s) begin
                x_d = 10'd0;
            end else if ({1'b0, x_q} != HT) begin
                x_d = x_q + 10'd1;
            end else begin
                x_d = x_q;
            end
            if (y_restart_s) begin
                y_d = 10'd0;
            end else if (h_edge_s && (y_q != 10'h3FF)) begin
                y_d = y_q + 10'd1;
            end else begin
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    assign active_s = h_ph_q & y_ph_q & (x_d >= HS) & (x_d < HE) & (y_d >= VS) & (y_d < VE);
    assign ax_s     = x_d - HS;
    assign ay_s     = y_d - VS;
    assign acc_en_s = pix_en & active_s & vga_r;

    // Timing/blanking checks; gated by phase flags so the first edges only set phase.
    always_comb begin
        err_h_s   = h_edge_s & h_ph_q & (({1'b0, x_q} + 11'd1) != HT);
        err_v_s   = v_edge_s & v_ph_q & (({1'b0, y_q} + 11'd1) != VT);
        err_o_s   = pix_en & h_ph_q & ~h_edge_s & (({1'b0, x_q} + 11'd1) == HT);
        err_b_s   = pix_en & h_ph_q & y_ph_q & ~active_s & (vga_r | vga_g | vga_b);
        any_err_s = err_h_s | err_v_s | err_o_s | err_b_s;
        unlock_s  = any_err_s & (state_q != ST_UNLOCKED);
        err_sum_s = {1'b0, err_q} + {8'd0, err_h_s} + {8'd0, err_v_s}
                  + {8'd0, err_o_s} + {8'd0, err_b_s};
        err_d     = err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
    end

    // Lock FSM; results are published only on frame ends that leave timing trusted.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        publish_s = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (v_edge_s && !any_err_s) begin
                    state_d = ST_MEASURING;
                    good_d  = 4'd0;
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_MEASURING: begin
                if (any_err_s) begin
                    state_d = ST_UNLOCKED;
                end else if (v_edge_s) begin
                    good_d = good_q + 4'd1;
                    if (good_d >= LF) begin
                        state_d   = ST_LOCKED;
                        publish_s = 1'b1;
                    end else begin
                        state_d = ST_MEASURING;
                    end
                end else begin
                    state_d = ST_MEASURING;
                end
            end
            ST_LOCKED: begin
                if (any_err_s) begin
                    state_d = ST_UNLOCKED;
                end else begin
                    state_d   = ST_LOCKED;
                    publish_s = v_edge_s;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                good_d  = 4'd0;
            end
        endcase
    end

    // FSM state, lock flag and saturating error counter.
    always_ff @(posedge ClkPort) begin
        if (reset) begin
            state_q  <= ST_UNLOCKED;
            good_q   <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            locked_q <= (state_d == ST_LOCKED);
            err_q    <= err_d;
        end
    end

    // Sync history, raster counters and phase flags advance only on strobes.
    always_ff @(posedge ClkPort) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            vs_pend_q <= 1'b0;
            h_ph_q    <= 1'b0;
            v_ph_q    <= 1'b0;
            y_ph_q    <= 1'b0;
        end else if (pix_en) begin
            hs_prev_q <= hs_s;
            vs_prev_q <= vs_s;
            x_q       <= x_d;
            y_q       <= y_d;
            if (y_restart_s) begin
                vs_pend_q <= 1'b0;
            end else if (v_edge_s) begin
                vs_pend_q <= 1'b1;
            end
            if (unlock_s) begin
                h_ph_q <= 1'b0;
                v_ph_q <= 1'b0;
                y_ph_q <= 1'b0;
            end else begin
                h_ph_q <= h_ph_q | h_edge_s;
                v_ph_q <= v_ph_q | v_edge_s;
                y_ph_q <= y_ph_q | y_restart_s;
            end
        end
    end

    // Per-frame red/green accumulators, cleared on every frame end.
    always_ff @(posedge ClkPort) begin
        if (reset || v_edge_s) begin
            acc_found_q <= 1'b0;
            acc_xmin_q  <= 10'd0;
            acc_xmax_q  <= 10'd0;
            acc_ymin_q  <= 10'd0;
            acc_ymax_q  <= 10'd0;
            acc_cnt_q   <= 19'd0;
            acc_col_q   <= 1'b0;
        end else if (acc_en_s) begin
            acc_found_q <= 1'b1;
            acc_xmin_q  <= (!acc_found_q || ax_s < acc_xmin_q) ? ax_s : acc_xmin_q;
            acc_xmax_q  <= (!acc_found_q || ax_s > acc_xmax_q) ? ax_s : acc_xmax_q;
            acc_ymin_q  <= (!acc_found_q || ay_s < acc_ymin_q) ? ay_s : acc_ymin_q;
            acc_ymax_q  <= (!acc_found_q || ay_s > acc_ymax_q) ? ay_s : acc_ymax_q;
            acc_cnt_q   <= (acc_cnt_q == 19'h7FFFF) ? acc_cnt_q : acc_cnt_q + 19'd1;
            acc_col_q   <= acc_col_q | vga_g;
        end
    end

    // Result registers and the one-cycle frame_valid strobe.
    always_ff @(posedge ClkPort) begin
        if (reset) begin
            fv_q    <= 1'b0;
            found_q <= 1'b0;
            xmin_q  <= 10'd0;
            xmax_q  <= 10'd0;
            ymin_q  <= 10'd0;
            ymax_q  <= 10'd0;
            cnt_q   <= 19'd0;
            col_q   <= 1'b0;
        end else begin
            fv_q <= publish_s;
            if (publish_s) begin
                found_q <= acc_found_q;
                xmin_q  <= acc_xmin_q;
                xmax_q  <= acc_xmax_q;
                ymin_q  <= acc_ymin_q;
                ymax_q  <= acc_ymax_q;
                cnt_q   <= acc_cnt_q;
                col_q   <= acc_col_q;
            end
        end
    end

    assign locked      = locked_q;
    assign frame_valid = fv_q;
    assign bird_found  = found_q;
    assign bird_x_min  = xmin_q;
    assign bird_x_max  = xmax_q;
    assign bird_y_min  = ymin_q;
    assign bird_y_max  = ymax_q;
    assign red_count   = cnt_q;
    assign collision   = col_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a reduced 64x40 raster
// (sync 8 px / 2 lines, active 48x32 starting at x=12, y=4).
module tb_vga_frame_monitor;
    localparam int HT = 64, VT = 40, HSW = 8, VSW = 2, HS = 12, VS = 4, HA = 48, VA = 32;

    logic        clk = 1'b0;
    logic        reset, pix_en, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;
    logic        locked, frame_valid, bird_found, collision;
    logic [9:0]  bird_x_min, bird_x_max, bird_y_min, bird_y_max;
    logic [18:0] red_count;
    logic [7:0]  err_count;

    typedef struct packed {
        logic        found;
        logic [9:0]  x0, x1, y0, y1;
        logic [18:0] cnt;
        logic        col;
    } res_t;

    res_t exp_q[$];
    res_t prev_exp, mon_act, mon_exp;
    int   checks = 0, failures = 0, gap_cnt = 0;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
    ) dut (
        .ClkPort(clk), .reset(reset), .pix_en(pix_en),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .locked(locked), .frame_valid(frame_valid), .bird_found(bird_found),
        .bird_x_min(bird_x_min), .bird_x_max(bird_x_max),
        .bird_y_min(bird_y_min), .bird_y_max(bird_y_max),
        .red_count(red_count), .collision(collision), .err_count(err_count)
    );

    // Bird box: ax 10..20, ay 8..18 -> 11x11 = 121 red pixels.
    function automatic res_t mk(input bit bird, input bit green);
        res_t r;
        if (bird) r = '{1'b1, 10'd10, 10'd20, 10'd8, 10'd18, 19'd121, green};
        else      r = '{1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 19'd0, 1'b0};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every frame_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            checks++;
            mon_act = '{bird_found, bird_x_min, bird_x_max, bird_y_min, bird_y_max, red_count, collision};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL frame_valid_unexpected actual=%0h expected=no_pulse", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL frame_result actual=%0h expected=%0h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic pix(input logic hsn, input logic vsn, input logic r, input logic g);
        gap_cnt++;
        if (gap_cnt % 5 == 0) begin
            @(negedge clk);
            pix_en = 1'b0;
            vga_h_sync = 1'($urandom); vga_v_sync = 1'($urandom);
            vga_r = 1'($urandom); vga_g = 1'($urandom); vga_b = 1'($urandom);
        end
        @(negedge clk);
        pix_en = 1'b1;
        vga_h_sync = hsn; vga_v_sync = vsn; vga_r = r; vga_g = g; vga_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_results", 64'({bird_found, bird_x_min, bird_x_max, bird_y_min, bird_y_max, red_count}), 64'd0);
        chk("rst_flags", 64'({locked, frame_valid, collision, err_count}), 64'd0);
        chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame; its first sample ends the previous frame (pushing prev_exp if pub).
    task automatic frame(input bit bird, input bit green, input bit pub,
                         input int short_ln, input int blank_ln, input int rst_ln,
                         input int chk_ln, input int chk_px, input bit exp_lock, input int exp_err);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_ln) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                int  ax, ay;
                bit  act, r, g;
                ax  = p - HS;
                ay  = l - VS;
                act = (p >= HS) && (p < HS + HA) && (l >= VS) && (l < VS + VA);
                r   = (act && bird && ax >= 10 && ax <= 20 && ay >= 8 && ay <= 18)
                      || (l == blank_ln && p == 10);
                g   = act && green && ax >= 15 && ax <= 30;
                if (l == 0 && p == 0 && pub) exp_q.push_back(prev_exp);
                if (l == rst_ln && p == 20) do_reset();
                pix(!(p < HSW), !(l < VSW), r, g);
                if (l == chk_ln && p == chk_px) begin
                    chk("locked", 64'(locked), 64'(exp_lock));
                    chk("err_count", 64'(err_count), 64'(exp_err));
                end
            end
        end
        prev_exp = mk(bird, green);
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0;
        vga_h_sync = 1'b1; vga_v_sync = 1'b1; vga_r = 1'b0; vga_g = 1'b0; vga_b = 1'b0;
        prev_exp = mk(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("init_results", 64'({bird_found, bird_x_min, bird_x_max, bird_y_min, bird_y_max, red_count}), 64'd0);
        chk("init_flags", 64'({locked, frame_valid, collision, err_count}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        frame(1, 0, 0, -1, -1, -1, -1, -1, 0, 0);  // F1: phase, enter measuring
        frame(1, 0, 0, -1, -1, -1,  0,  0, 0, 0);  // F1 end: good=1, no publish
        frame(1, 0, 1, -1, -1, -1,  0,  0, 1, 0);  // F2 end: locked, publish
        frame(1, 1, 1, -1, -1, -1,  0,  0, 1, 0);  // F3 end publish; F4 has pipes
        frame(1, 0, 1, 20, -1, -1, 21,  0, 0, 1);  // F4 end collision; short line 20
        frame(1, 0, 0, -1, -1, -1,  0,  0, 0, 1);  // F5 end errored: no publish
        frame(0, 0, 0, -1, -1, -1,  0,  0, 0, 1);  // F6 end good=1; F7 has no red
        frame(1, 0, 1, -1, -1, -1,  0,  0, 1, 1);  // F7 end relock, empty result
        frame(1, 0, 1, -1, 10, -1, 10, 10, 0, 2);  // F8 end publish; red in blanking
        frame(1, 0, 0, -1, -1, -1,  0,  0, 0, 2);  // F9 end errored
        frame(1, 0, 0, -1, -1, -1,  0,  0, 0, 2);  // F10 end good=1
        frame(1, 0, 1, -1, -1, 30,  0,  0, 1, 2);  // F11 end locked; reset at line 30
        frame(1, 0, 0, -1, -1, -1,  0,  0, 0, 0);  // partial frame end: measuring
        frame(1, 0, 0, -1, -1, -1,  0,  0, 0, 0);  // 1st complete frame end: good=1

        exp_q.push_back(prev_exp);                 // 2nd complete frame end publishes
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_locked", 64'(locked), 64'd1);
        chk("final_err", 64'(err_count), 64'd0);
        @(negedge clk);
        pix_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
